// File: rtl/serial_mem_loader_pkg.sv
// Shared types and constants for the serial memory loader.
package serial_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TGT   = 3'd1,
    ST_CNT   = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [7:0] HDR_DEFAULT  = 8'hA5;
  localparam logic       MEM_SEL_IROM = 1'b0;
  localparam logic       MEM_SEL_DRAM = 1'b1;

endpackage

// File: rtl/serial_mem_loader_uart_rx.sv
// UART byte receiver (8N1, LSB first) on an already-synchronized rx line.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on rx_sync
// RX_START | counting to mid start bit, rejects glitches
// RX_DATA  | sampling 8 data bits at mid-bit
// RX_STOP  | sampling the stop bit, then straight back to RX_IDLE
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_sync,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [2:0]       bit_idx, nxt_bit_idx;
  logic [7:0]       shift, nxt_shift;
  logic             rx_prev;
  logic             nxt_valid, nxt_ferr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rx_prev    <= 1'b1;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      bit_idx    <= nxt_bit_idx;
      shift      <= nxt_shift;
      rx_prev    <= rx_sync;
      byte_valid <= nxt_valid;
      frame_err  <= nxt_ferr;
    end
  end

  // Down-counter: each bit is sampled when the count reaches terminal zero.
  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt;
    nxt_bit_idx = bit_idx;
    nxt_shift   = shift;
    nxt_valid   = 1'b0;
    nxt_ferr    = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          nxt_state = RX_START;
          nxt_cnt   = HALF_TC;
        end
      end
      RX_START: begin
        if (cnt != '0) begin
          nxt_cnt = cnt - CNT_W'(1);
        end else if (rx_sync) begin
          nxt_state = RX_IDLE;
        end else begin
          nxt_state   = RX_DATA;
          nxt_cnt     = FULL_TC;
          nxt_bit_idx = '0;
        end
      end
      RX_DATA: begin
        if (cnt != '0) begin
          nxt_cnt = cnt - CNT_W'(1);
        end else begin
          nxt_shift = {rx_sync, shift[7:1]};
          nxt_cnt   = FULL_TC;
          if (bit_idx == 3'd7) nxt_state = RX_STOP;
          else nxt_bit_idx = bit_idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt != '0) begin
          nxt_cnt = cnt - CNT_W'(1);
        end else begin
          nxt_state = RX_IDLE;
          if (rx_sync) nxt_valid = 1'b1;
          else nxt_ferr = 1'b1;
        end
      end
      default: nxt_state = RX_IDLE;
    endcase
  end

  assign byte_data = shift;

endmodule

// File: rtl/serial_mem_loader.sv
// Host-to-memory loader: parses HDR/TGT/CNT/data frames from the UART and
// writes big-endian 32-bit words into IROM or DATARAM while holding the CPU.
//
// state    | meaning
// ST_IDLE  | hunting for the header byte, CPU running
// ST_TGT   | expecting the target-select byte
// ST_CNT   | expecting the word-count byte
// ST_DATA  | assembling the next word from 4 bytes
// ST_WRITE | one-cycle write strobe for the assembled word
// ST_DONE  | one-cycle completion pulse
module serial_mem_loader
  import serial_mem_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         ADDR_W       = 8,
  parameter logic [7:0] HDR          = HDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int CW = ((ADDR_W > 8) ? ADDR_W : 8) + 1;
  localparam logic [CW-1:0] MAX_WORDS = CW'(2 ** ADDR_W);

  logic              rx_meta, rx_sync;
  logic              byte_valid, frame_err;
  logic [7:0]        byte_data;

  state_t            state, nxt_state;
  logic              sel_q, nxt_sel;
  logic [ADDR_W-1:0] addr_q, nxt_addr;
  logic [CW-1:0]     remaining, nxt_remaining, req_words;
  logic [1:0]        byte_idx, nxt_byte_idx;
  logic [31:0]       word_q, nxt_word;
  logic              err_q, nxt_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_sync    (rx_sync),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  // CNT = 0 means 256 words; the clip keeps the last address inside the port.
  always_comb begin
    req_words = (byte_data == 8'd0) ? CW'(256) : CW'(byte_data);
    if (req_words > MAX_WORDS) req_words = MAX_WORDS;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel_q     <= MEM_SEL_IROM;
      addr_q    <= '0;
      remaining <= '0;
      byte_idx  <= '0;
      word_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= nxt_state;
      sel_q     <= nxt_sel;
      addr_q    <= nxt_addr;
      remaining <= nxt_remaining;
      byte_idx  <= nxt_byte_idx;
      word_q    <= nxt_word;
      err_q     <= nxt_err;
    end
  end

  always_comb begin
    nxt_state     = state;
    nxt_sel       = sel_q;
    nxt_addr      = addr_q;
    nxt_remaining = remaining;
    nxt_byte_idx  = byte_idx;
    nxt_word      = word_q;
    nxt_err       = err_q;
    if (frame_err) begin
      nxt_err   = 1'b1;
      nxt_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (byte_valid && byte_data == HDR) begin
            nxt_err   = 1'b0;
            nxt_state = ST_TGT;
          end
        end
        ST_TGT: begin
          if (byte_valid) begin
            if (byte_data[7:1] != 7'd0) begin
              nxt_err   = 1'b1;
              nxt_state = ST_IDLE;
            end else begin
              nxt_sel   = byte_data[0] ? MEM_SEL_DRAM : MEM_SEL_IROM;
              nxt_state = ST_CNT;
            end
          end
        end
        ST_CNT: begin
          if (byte_valid) begin
            nxt_remaining = req_words;
            nxt_addr      = '0;
            nxt_byte_idx  = '0;
            nxt_state     = ST_DATA;
          end
        end
        ST_DATA: begin
          if (byte_valid) begin
            nxt_word = {word_q[23:0], byte_data};
            if (byte_idx == 2'd3) nxt_state = ST_WRITE;
            else nxt_byte_idx = byte_idx + 2'd1;
          end
        end
        ST_WRITE: begin
          nxt_remaining = remaining - CW'(1);
          nxt_byte_idx  = '0;
          // Address is held on the final word so it never wraps past the top.
          if (remaining == CW'(1)) begin
            nxt_state = ST_DONE;
          end else begin
            nxt_addr  = addr_q + ADDR_W'(1);
            nxt_state = ST_DATA;
          end
        end
        ST_DONE: nxt_state = ST_IDLE;
        default: nxt_state = ST_IDLE;
      endcase
    end
  end

  assign mem_we    = (state == ST_WRITE);
  assign done      = (state == ST_DONE);
  assign cpu_hold  = (state != ST_IDLE);
  assign mem_sel   = sel_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;
  assign err       = err_q;

endmodule

// File: tb/tb_serial_mem_loader.sv
// Scoreboard bench for serial_mem_loader: frames are built from random data,
// expected writes are computed per frame and checked by an independent monitor.
module tb_serial_mem_loader;

  localparam int CPB      = 4;
  localparam int ADDR_W   = 8;
  localparam int BYTE_CYC = 10 * CPB;
  // From the start-bit cycle of a word's 4th byte to its mem_we cycle:
  // 2 sync flops + edge detect + half bit + 9 bits + byte_valid + WRITE.
  localparam int LAT = 42;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx  = 1'b1;
  logic              mem_we, mem_sel, cpu_hold, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  serial_mem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .HDR(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                at;
  } wr_t;

  wr_t        exp_wr[$];
  int         exp_done[$];
  logic [7:0] payload[$];
  int         errors = 0;
  int         checks = 0;
  logic       hold_off_due = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    int  d;
    if (hold_off_due) begin
      check("hold_drop_after_done", 64'(cpu_hold), 64'd0);
      hold_off_due = 1'b0;
    end
    if (mem_we) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_write", 64'(mem_we), 64'd0);
      end else begin
        e = exp_wr.pop_front();
        check("wr_cycle", 64'(cyc), 64'(e.at));
        check("wr_sel", 64'(mem_sel), 64'(e.sel));
        check("wr_addr", 64'(mem_addr), 64'(e.addr));
        check("wr_data", 64'(mem_wdata), 64'(e.data));
        check("wr_hold", 64'(cpu_hold), 64'd1);
      end
    end
    if (done) begin
      if (exp_done.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        d = exp_done.pop_front();
        check("done_cycle", 64'(cyc), 64'(d));
        check("done_hold", 64'(cpu_hold), 64'd1);
        hold_off_due = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_payload(input int n_words);
    payload.delete();
    for (int i = 0; i < 4 * n_words; i++) payload.push_back(8'($urandom_range(0, 255)));
  endtask

  // Word i of a frame is the big-endian pack of payload bytes 4i..4i+3.
  task automatic expect_words(input logic sel, input int n, input int first_data_start);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.sel  = sel;
      e.addr = ADDR_W'(i);
      e.data = {payload[4*i], payload[4*i+1], payload[4*i+2], payload[4*i+3]};
      e.at   = first_data_start + BYTE_CYC * (4 * i + 3) + LAT;
      exp_wr.push_back(e);
    end
    exp_done.push_back(first_data_start + BYTE_CYC * (4 * n - 1) + LAT + 1);
  endtask

  task automatic load_frame(input logic [7:0] tgt, input logic [7:0] cnt);
    int n;
    n = (cnt == 8'd0) ? 256 : int'(cnt);
    expect_words(tgt[0], n, cyc + 3 * BYTE_CYC);
    send_byte(8'hA5);
    send_byte(tgt);
    send_byte(cnt);
    foreach (payload[i]) send_byte(payload[i]);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_pending_writes"}, 64'(exp_wr.size()), 64'd0);
    check({tag, "_pending_done"}, 64'(exp_done.size()), 64'd0);
  endtask

  int s0;
  int n_rand;

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check("reset_outputs", 64'({mem_we, mem_sel, mem_addr, mem_wdata, cpu_hold, done, err}), 64'd0);
    rst = 1'b0;
    idle(10);

    // Single word into DATARAM, with cpu_hold rise timing.
    payload = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    s0 = cyc;
    fork
      load_frame(8'h01, 8'h01);
      begin
        wait_until(s0 + BYTE_CYC + 1);
        check("hold_low_before_hdr", 64'(cpu_hold), 64'd0);
        wait_until(s0 + BYTE_CYC + 2);
        check("hold_high_after_hdr", 64'(cpu_hold), 64'd1);
      end
    join
    idle(8);
    check_drained("single");
    check("single_err", 64'(err), 64'd0);

    // Three words into IROM, bytes 00..0B.
    payload.delete();
    for (int i = 0; i < 12; i++) payload.push_back(8'(i));
    load_frame(8'h00, 8'h03);
    idle(8);
    check_drained("multi");

    // Garbage ahead of the header is ignored.
    send_byte(8'h3C);
    send_byte(8'h5A);
    idle(4);
    check("garbage_err", 64'(err), 64'd0);
    check("garbage_hold", 64'(cpu_hold), 64'd0);
    fill_payload(2);
    load_frame(8'h01, 8'h02);
    idle(8);
    check_drained("after_garbage");

    // Stop bit held low on the 2nd data byte.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hDE);
    send_byte(8'hAD, 1'b0);
    idle(3);
    check("ferr_err", 64'(err), 64'd1);
    check("ferr_hold", 64'(cpu_hold), 64'd0);
    idle(40);
    fill_payload(1);
    load_frame(8'h01, 8'h01);
    idle(8);
    check("ferr_recover_err", 64'(err), 64'd0);
    check_drained("ferr_recover");

    // Bad target byte; trailing bytes must be ignored in IDLE.
    send_byte(8'hA5);
    send_byte(8'h02);
    idle(3);
    check("badtgt_err", 64'(err), 64'd1);
    check("badtgt_hold", 64'(cpu_hold), 64'd0);
    send_byte(8'h01);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    idle(8);
    check("badtgt_err_sticky", 64'(err), 64'd1);

    // One-cycle glitch while waiting for TGT must not become a byte.
    fill_payload(1);
    s0 = cyc;
    expect_words(1'b1, 1, s0 + BYTE_CYC + 24 + 2 * BYTE_CYC);
    send_byte(8'hA5);
    rx = 1'b0;
    @(posedge clk);
    #1;
    idle(23);
    send_byte(8'h01);
    send_byte(8'h01);
    foreach (payload[i]) send_byte(payload[i]);
    idle(8);
    check("glitch_err", 64'(err), 64'd0);
    check_drained("glitch");

    // Reset during byte 3 of a word.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_frame", 64'({mem_we, mem_sel, mem_addr, mem_wdata, cpu_hold, done, err}), 64'd0);
    rst = 1'b0;
    idle(50);
    fill_payload(2);
    load_frame(8'h00, 8'h02);
    idle(8);
    check_drained("after_reset");

    // Random back-to-back frames; one carries the header value as data.
    for (int k = 0; k < 4; k++) begin
      n_rand = $urandom_range(1, 5);
      fill_payload(n_rand);
      if (k == 1) payload[1] = 8'hA5;
      load_frame(8'($urandom_range(0, 1)), 8'(n_rand));
    end
    idle(8);
    check_drained("random");
    check("final_hold", 64'(cpu_hold), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_mem_loader.md
Name: serial_mem_loader

Overview:
- Debug/program loader: receives a framed byte stream on a UART line, assembles 32-bit big-endian words, and writes them into IROM or DATARAM through a word-addressed write port.
- It is the input counterpart of the switch-selected DATARAM readout to the 7-segment display: the display path reads memory out to the board, and this block writes memory in from the host.
- Holds the pipeline (PC update and all pipeline registers) stalled while a frame is in flight.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 4.
- ADDR_W, 8, width of word-address output; frame word count is capped at 2^ADDR_W.
- HDR, 8'hA5, frame header byte.

Ports:
- clk  in  1  system clock (the divided clock that drives the pipeline).
- rst  in  1  synchronous, active-high reset.
- rx  in  1  UART line, idle high, asynchronous to clk.
- mem_we  out  1  one-cycle write strobe.
- mem_sel  out  1  target memory: 0 = IROM, 1 = DATARAM.
- mem_addr  out  ADDR_W  word address (byte address >> 2).
- mem_wdata  out  32  write data.
- cpu_hold  out  1  stall request to the pipeline; ORed into StallF/StallD externally.
- done  out  1  one-cycle pulse after the last word of a frame is written.
- err  out  1  sticky error flag.

Behaviour:
- Reset:
  - All outputs are 0. FSM goes to IDLE.
  - The rx synchronizer flops reset to 1.
  - Byte and word counters reset to 0.
- rx sync: two-flop synchronizer. All logic uses the synchronized rx only.
- Byte receiver:
  - A falling edge in the RX_IDLE state starts a bit counter.
  - The start bit is re-sampled at CLKS_PER_BIT/2; if it is high, abort silently back to RX_IDLE.
  - 8 data bits are sampled LSB first at mid-bit, then the stop bit is sampled at mid-bit.
  - Stop = 1: emit byte_valid for 1 cycle together with byte_data.
  - Stop = 0: emit frame_err for 1 cycle.
  - After the stop sample, the receiver returns to RX_IDLE immediately, so a back-to-back start bit is accepted.
- Frame format: HDR, TGT, CNT, then 4*N data bytes.
  - TGT bit0 = mem_sel. TGT bits 7:1 must be 0.
  - CNT: N = CNT, with CNT = 0 meaning 256 words. N is clipped to 2^ADDR_W.
- Frame FSM:
  - IDLE:
    - byte == HDR: clear err, assert cpu_hold, go to TGT.
    - Any other byte: ignored, stay in IDLE.
  - TGT:
    - Valid byte: latch mem_sel, go to CNT.
    - Bits 7:1 nonzero: set err, drop cpu_hold, go to IDLE.
  - CNT: latch the remaining-word count, set mem_addr = 0, clear the byte index, go to DATA.
  - DATA: shift each byte into a 32-bit assembly register (first byte received = bits 31:24). When the 4th byte is shifted in, go to WRITE.
  - WRITE (1 cycle):
    - mem_we = 1 and mem_wdata = assembled word, at the current mem_addr.
    - The next cycle: mem_addr increments and the remaining count decrements.
    - If the count reaches 0, go to DONE; otherwise return to DATA.
  - DONE (1 cycle): done = 1, cpu_hold drops on the following cycle, go to IDLE.
- Latency: mem_we is asserted exactly 1 cycle after the byte_valid of the 4th byte of each word.
- mem_addr, mem_sel and mem_wdata are stable whenever mem_we = 1.
- frame_err while in any state other than IDLE: set err, abort the frame, drop cpu_hold next cycle, go to IDLE. Words already written stay written; there is no rollback.
- frame_err while in IDLE: set err, stay in IDLE.
- Address wrap: mem_addr never wraps within a frame, because the count clip guarantees the last address is 2^ADDR_W - 1.
- rst asserted mid-frame: everything returns to reset state within 1 cycle and cpu_hold = 0. Partial words are discarded.
- A new HDR byte received while in DATA is treated as data, not as a resync.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE, TGT, CNT, DATA, WRITE, DONE);
  - HDR_DEFAULT;
  - the MEM_SEL_IROM / MEM_SEL_DRAM constants.
- One sub-module, uart_rx_byte:
  - parameter CLKS_PER_BIT;
  - ports: clk, rst, rx_sync, byte_valid, byte_data[7:0], frame_err.
- The frame FSM is in serial_mem_loader.

Test Plan:
- Setup: CLKS_PER_BIT = 4, bytes driven back to back.
- Single word: send A5 01 01 DE AD BE EF -> one mem_we with sel = 1, addr = 0, wdata = 32'hDEADBEEF. done pulses 1 cycle after that write. cpu_hold is high from the cycle after HDR until the cycle after done.
- Multi word: send A5 00 03 followed by 12 bytes 00..0B -> 3 writes with sel = 0, addr 0/1/2, data 00010203 / 04050607 / 08090A0B, exactly 1 cycle after each 4th byte.
- Garbage before HDR: send 3C 5A, then a valid frame -> no writes and no err before HDR; the frame then loads normally.
- Framing error: during the 2nd data byte, hold the stop bit low -> err = 1, cpu_hold = 0, no mem_we. A following valid frame clears err and writes correctly.
- Bad target: send A5 02 -> err = 1, FSM in IDLE, no writes.
- Reset mid-frame: assert rst during byte 3 of a word -> all outputs 0 the next cycle, no mem_we. A fresh frame afterwards writes starting at addr 0.
- Glitch: a 1-cycle low pulse on rx -> start bit rejected, no byte_valid, no err.
